dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU core's load/store port and a secondary DMA/debug port. It sits between the CPU core and the data memory in the computer top level. Each requester sees a request/acknowledge handshake and the CPU gets a stall signal. Arbitration is registered, and the memory is driven from exactly one owner per cycle.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `CNT_W`, default 16: width of the conflict counter.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: CPU write enable (1 = store).
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in DW: CPU store data.
- `cpu_ack` out 1: the CPU access is performed this cycle.
- `cpu_rdata` out DW: load data, valid while `cpu_ack` = 1.
- `cpu_stall` out 1: `cpu_req & ~cpu_ack`.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata` in (1/1/AW/DW): DMA port, same meaning as the CPU port.
- `dma_ack` out 1, `dma_rdata` out DW: DMA acknowledge and read data.
- `mem_we` out 1: data memory write enable.
- `mem_addr` out AW: data memory address.
- `mem_wdata` out DW: data memory write data.
- `mem_rdata` in DW: data memory read data (combinational read).
- `owner` out 2: current owner; 00 = none, 01 = CPU, 10 = DMA.
- `conflict_cnt` out CNT_W: saturating count of contention cycles.

## Operation
- FSM states: IDLE, GNT_CPU, GNT_DMA. The state register is `owner`.
- Next-state decision is made every cycle, in any state, from the current `cpu_req`/`dma_req`:
  - neither request → IDLE;
  - one request → grant that requester;
  - both requests → winner per the policy below.
- In GNT_X:
  - `mem_addr`, `mem_wdata` and `mem_we` come from port X's inputs;
  - `X_ack` = `X_req`;
  - `X_rdata` = `mem_rdata`.
- In GNT_X, if `X_req` is low (request withdrawn), the cycle is wasted: no ack and `mem_we` = 0.
- In IDLE: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, both acks 0.
- The non-owner's `rdata` output is 0.
- Requester rules:
  - hold `req`, `we`, `addr` and `wdata` stable until ack;
  - after ack, `req` still high = a new request (back-to-back allowed).
- Register `last` records the last-served port. It updates on each acked cycle.
- Contention: `conflict_cnt` increments on every cycle where both `req` are high. It saturates at all-ones and never wraps.
- A write commits at the rising edge ending its GNT cycle.

## Timing
- Request latency:
  - `req` rising in cycle N while the port is not owner → grant in cycle N+1 → ack, read data and write in N+1;
  - `cpu_stall` = 1 during cycle N.
- Throughput: one access per cycle. A port that keeps `req` high while the other is idle receives ack on consecutive cycles.
- Round-robin tie (macro defined): both requesting → grant goes to the port that is not `last`. Alternating grants give ack every other cycle to each port.
- Reset values:
  - state IDLE, `owner` = 00;
  - all acks 0, `cpu_stall` = `cpu_req`;
  - `mem_we`/`mem_addr`/`mem_wdata` = 0, all `rdata` = 0;
  - `last` = DMA, so the CPU wins the first tie;
  - `conflict_cnt` = 0.
- Reset mid-operation: `clrn` low drops `mem_we` immediately (asynchronous). A write in progress is not committed unless the edge occurred before reset assertion.

## Configuration
- Macro `DMEM_ARB_ROUND_ROBIN_EN`.
- Defined: ties are resolved round-robin using `last`. Neither port can wait more than 1 cycle beyond its first grant opportunity.
- Not defined:
  - fixed priority, CPU always wins ties;
  - the DMA may starve while `cpu_req` is continuously high;
  - `last` is still maintained but ignored.

## Test plan
- Reset with `cpu_req` = 1 → `owner` = 00, `cpu_ack` = 0, `cpu_stall` = 1, `mem_we` = 0, `conflict_cnt` = 0. After release, the next cycle has `owner` = 01 and `cpu_ack` = 1.
- CPU store: addr 0x10, data 0xDEADBEEF, then load of 0x10 → the store is acked with `mem_we` = 1 for one cycle. The load ack cycle shows `cpu_rdata` = 0xDEADBEEF.
- Both ports request continuously for 6 cycles:
  - round-robin build → grants CPU, DMA, CPU, DMA, CPU;
  - fixed build → 5 CPU grants, `dma_ack` never 1;
  - both builds → `conflict_cnt` = 6.
- DMA alone, `req` held for 4 cycles → 1 wait cycle, then 3 consecutive `dma_ack` cycles at addresses 0x20, 0x24, 0x28.
- `clrn` asserted low mid-cycle during a DMA write to 0x30 (value 0x1234) → `mem_we` drops immediately, and memory at 0x30 keeps its old value.
- Force `conflict_cnt` to 0xFFFE (CNT_W = 16), then 3 contention cycles → it holds at 0xFFFF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store
// port and a DMA/debug port. Ownership is registered (owner = FSM state), the
// memory is driven by exactly one owner per cycle, and contention cycles are
// counted in a saturating counter.
//
// Build option: define DMEM_ARB_ROUND_ROBIN_EN to resolve ties round-robin
// using the last-served port. Without it the CPU always wins a tie.
//
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until it sees ack. The access (read data, write commit) happens in the ack
// cycle. Keeping req high after ack is a new back-to-back request.
module dmem_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic             cpu_ack,
    output logic [DW-1:0]    cpu_rdata,
    output logic             cpu_stall,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [AW-1:0]    dma_addr,
    input  logic [DW-1:0]    dma_wdata,
    output logic             dma_ack,
    output logic [DW-1:0]    dma_rdata,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [1:0]       owner,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_GNT_CPU = 2'b01;
    localparam logic [1:0] ST_GNT_DMA = 2'b10;

    // last-served encoding
    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_DMA = 1'b1;

    logic [1:0]       r_owner;
    logic             r_last;
    logic [CNT_W-1:0] r_conflict_cnt;

    logic             w_cpu_ack;
    logic             w_dma_ack;
    logic             w_both_req;
    logic             w_last_now;
    logic             w_tie_to_dma;
    logic [1:0]       w_next_owner;

    // An ack is given only to the current owner while it still requests
    assign w_cpu_ack  = (r_owner == ST_GNT_CPU) & cpu_req;
    assign w_dma_ack  = (r_owner == ST_GNT_DMA) & dma_req;
    assign w_both_req = cpu_req & dma_req;

    // Last-served including this cycle's ack, so alternation works on
    // back-to-back ties rather than granting the same port twice.
    assign w_last_now = w_cpu_ack ? LAST_CPU :
                        w_dma_ack ? LAST_DMA : r_last;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    assign w_tie_to_dma = (w_last_now == LAST_CPU);
`else
    // Fixed priority: CPU wins every tie; last-served is tracked but ignored.
    assign w_tie_to_dma = 1'b0 & w_last_now;
`endif

    // Next owner decided every cycle from the current requests
    always_comb begin
        w_next_owner = ST_IDLE;
        if (w_both_req)
            w_next_owner = w_tie_to_dma ? ST_GNT_DMA : ST_GNT_CPU;
        else if (cpu_req)
            w_next_owner = ST_GNT_CPU;
        else if (dma_req)
            w_next_owner = ST_GNT_DMA;
    end

    // Ownership register (FSM state)
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_owner <= ST_IDLE;
        else
            r_owner <= w_next_owner;
    end

    // Last-served port, updated only on acked cycles; DMA after reset so the CPU wins the first tie
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_last <= LAST_DMA;
        else if (w_cpu_ack)
            r_last <= LAST_CPU;
        else if (w_dma_ack)
            r_last <= LAST_DMA;
    end

    // Saturating count of cycles where both ports request
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_conflict_cnt <= '0;
        else if (w_both_req && (r_conflict_cnt != {CNT_W{1'b1}}))
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end

    // Memory and read-data steering from the current owner; a withdrawn request never writes
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        dma_rdata = '0;
        case (r_owner)
            ST_GNT_CPU: begin
                mem_we    = cpu_we & cpu_req;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_rdata = mem_rdata;
            end
            ST_GNT_DMA: begin
                mem_we    = dma_we & dma_req;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                dma_rdata = mem_rdata;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign cpu_ack      = w_cpu_ack;
    assign dma_ack      = w_dma_ack;
    assign cpu_stall    = cpu_req & ~w_cpu_ack;
    assign owner        = r_owner;
    assign conflict_cnt = r_conflict_cnt;

endmodule
